mix_saturator: RTL and testbench

- Parametrised, time-multiplexed successor to the single-sample combinational clip stage.
- Accumulates NUM_CH signed voice samples per output frame into a guard-bit accumulator.
- Applies an optional arithmetic attenuation shift, then saturates the sum to OUT_W bits.
- Reports per-frame clip direction and a sticky saturating clip counter; sits between voice outputs and the filter/DAC path.

---
 rtl/mix_saturator.sv | 154 +++++++++++++++
 tb/tb_mix_saturator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_saturator.sv
// Time-multiplexed voice mixer: sums NUM_CH signed samples per frame, applies an
// arithmetic attenuation shift, saturates to OUT_W bits and tracks clipped frames.
module mix_saturator #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int NUM_CH = 4,
  parameter int SHIFT  = 0,
  parameter int CNT_W  = 8
) (
  input  logic                    iClk,
  input  logic                    iResetN,
  input  logic                    iStart,
  input  logic                    iValid,
  input  logic signed [IN_W-1:0]  iSample,
  input  logic                    iClearCount,
  output logic                    oReady,
  output logic                    oValid,
  output logic signed [OUT_W-1:0] oOut,
  output logic                    oClipPos,
  output logic                    oClipNeg,
  output logic [CNT_W-1:0]        oClipCount
);

  localparam int ACC_W = IN_W + $clog2(NUM_CH);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  // Output rails expressed at accumulator width so the comparison is exact.
  localparam logic signed [ACC_W-1:0] MAX_POS =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_NEG =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic                    clip_pos_q, clip_pos_d;
  logic                    clip_neg_q, clip_neg_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] shifted;
  logic                    sat_pos;
  logic                    sat_neg;

  assign sample_ext = {{(ACC_W-IN_W){iSample[IN_W-1]}}, iSample};
  assign shifted    = acc_q >>> SHIFT;
  assign sat_pos    = shifted > MAX_POS;
  assign sat_neg    = shifted < MIN_NEG;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    out_d      = out_q;
    clip_pos_d = 1'b0;
    clip_neg_d = 1'b0;
    valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = ACCUM;
          acc_d   = '0;
          idx_d   = '0;
        end
      end

      ACCUM: begin
        // A restart drops the partial frame, including any same-cycle sample.
        if (iStart) begin
          acc_d = '0;
          idx_d = '0;
        end else if (iValid) begin
          acc_d = acc_q + sample_ext;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = SAT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      SAT: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (sat_pos) begin
          out_d      = {1'b0, {(OUT_W-1){1'b1}}};
          clip_pos_d = 1'b1;
        end else if (sat_neg) begin
          out_d      = {1'b1, {(OUT_W-1){1'b0}}};
          clip_neg_d = 1'b1;
        end else begin
          out_d = shifted[OUT_W-1:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Clear beats a coinciding increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (iClearCount) begin
      cnt_d = '0;
    end else if (valid_q && (clip_pos_q || clip_neg_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      out_q      <= '0;
      clip_pos_q <= 1'b0;
      clip_neg_q <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      clip_pos_q <= clip_pos_d;
      clip_neg_q <= clip_neg_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oReady     = (state_q == ACCUM);
  assign oValid     = valid_q;
  assign oOut       = out_q;
  assign oClipPos   = clip_pos_q;
  assign oClipNeg   = clip_neg_q;
  assign oClipCount = cnt_q;

endmodule

// File: tb/tb_mix_saturator.sv
// Bench for mix_saturator: one unshifted and one SHIFT=2 instance share stimulus
// and are compared against an arithmetic frame model.
module tb_mix_saturator;

  logic clk = 1'b0;
  logic rst_n;
  logic start, valid, clr;
  logic signed [15:0] sample;

  logic rdy0, vld0, cp0, cn0;
  logic signed [15:0] out0;
  logic [7:0] cnt0;
  logic rdy2, vld2, cp2, cn2;
  logic signed [15:0] out2;
  logic [7:0] cnt2;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt0 = 0;
  int exp_cnt2 = 0;
  int pulses0  = 0;
  int pulses2  = 0;
  int frames   = 0;

  always #5 clk = ~clk;

  mix_saturator #(.IN_W(16), .OUT_W(16), .NUM_CH(4), .SHIFT(0), .CNT_W(8)) u_dut0 (
    .iClk(clk), .iResetN(rst_n), .iStart(start), .iValid(valid), .iSample(sample),
    .iClearCount(clr), .oReady(rdy0), .oValid(vld0), .oOut(out0),
    .oClipPos(cp0), .oClipNeg(cn0), .oClipCount(cnt0)
  );

  mix_saturator #(.IN_W(16), .OUT_W(16), .NUM_CH(4), .SHIFT(2), .CNT_W(8)) u_dut2 (
    .iClk(clk), .iResetN(rst_n), .iStart(start), .iValid(valid), .iSample(sample),
    .iClearCount(clr), .oReady(rdy2), .oValid(vld2), .oOut(out2),
    .oClipPos(cp2), .oClipNeg(cn2), .oClipCount(cnt2)
  );

  always @(posedge clk) begin
    if (vld0) pulses0++;
    if (vld2) pulses2++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Frame model: floor-divide the sum by 2^sh, then clamp to 16-bit signed.
  function automatic void ref_mix(input int sum, input int sh,
                                  output int val, output bit pos, output bit neg);
    int div;
    int s;
    div = 1 << sh;
    if (sum >= 0) s = sum / div;
    else          s = -((-sum + div - 1) / div);
    pos = (s > 32767);
    neg = (s < -32768);
    val = pos ? 32767 : (neg ? -32768 : s);
  endfunction

  function automatic int bump(input int c, input bit clipped, input bit cleared);
    if (cleared) return 0;
    if (clipped && c < 255) return c + 1;
    return c;
  endfunction

  // Drive one clock's worth of inputs; entered and left on a falling edge.
  task automatic cyc(input bit st, input bit v, input int smp);
    start  = st;
    valid  = v;
    sample = 16'(smp);
    @(negedge clk);
    start  = 1'b0;
    valid  = 1'b0;
  endtask

  task automatic send_sample(input int smp, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 0);
    check("ready_accum0", rdy0, 1);
    check("ready_accum2", rdy2, 1);
    cyc(1'b0, 1'b1, smp);
  endtask

  task automatic begin_frame();
    check("ready_idle0", rdy0, 0);
    check("ready_idle2", rdy2, 0);
    cyc(1'b1, 1'b0, 0);
  endtask

  // Called on the falling edge right after the final sample was accepted.
  task automatic finish_frame(input int sum, input bit clear_at_valid);
    int v0, v2;
    bit p0, n0, p2, n2;
    ref_mix(sum, 0, v0, p0, n0);
    ref_mix(sum, 2, v2, p2, n2);
    check("ready_sat0", rdy0, 0);
    check("valid_early0", vld0, 0);
    check("valid_early2", vld2, 0);
    @(negedge clk);
    frames++;
    check("valid_pulse0", vld0, 1);
    check("valid_pulse2", vld2, 1);
    check("out0", out0, v0);
    check("clip_pos0", cp0, p0);
    check("clip_neg0", cn0, n0);
    check("out2", out2, v2);
    check("clip_pos2", cp2, p2);
    check("clip_neg2", cn2, n2);
    check("ready_after0", rdy0, 0);
    exp_cnt0 = bump(exp_cnt0, p0 | n0, clear_at_valid);
    exp_cnt2 = bump(exp_cnt2, p2 | n2, clear_at_valid);
    clr = clear_at_valid;
    @(negedge clk);
    clr = 1'b0;
    check("valid_drop0", vld0, 0);
    check("valid_drop2", vld2, 0);
    check("flags_drop0", {cp0, cn0}, 0);
    check("flags_drop2", {cp2, cn2}, 0);
    check("out_hold0", out0, v0);
    check("out_hold2", out2, v2);
    check("clip_cnt0", cnt0, exp_cnt0);
    check("clip_cnt2", cnt2, exp_cnt2);
    check("pulses0", pulses0, frames);
    check("pulses2", pulses2, frames);
  endtask

  task automatic run_frame(input int s[4], input bit gaps, input bit clear_at_valid);
    int sum = 0;
    begin_frame();
    for (int i = 0; i < 4; i++) begin
      send_sample(s[i], gaps);
      sum += s[i];
    end
    finish_frame(sum, clear_at_valid);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s[4];
    logic signed [15:0] r;

    rst_n = 1'b0; start = 1'b0; valid = 1'b0; clr = 1'b0; sample = '0;
    repeat (2) @(negedge clk);
    check("rst_out0", out0, 0);
    check("rst_valid0", vld0, 0);
    check("rst_ready0", rdy0, 0);
    check("rst_flags0", {cp0, cn0}, 0);
    check("rst_cnt0", cnt0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame('{100, 200, -50, 7}, 1'b0, 1'b0);
    run_frame('{32767, 32767, 32767, 32767}, 1'b0, 1'b0);
    run_frame('{-32768, -32768, -32768, -32768}, 1'b0, 1'b0);
    check("cnt_two_clips", cnt0, 2);

    run_frame('{32767, 0, 0, 0}, 1'b0, 1'b0);
    run_frame('{32767, 1, 0, 0}, 1'b0, 1'b0);
    run_frame('{-32768, 0, 0, 0}, 1'b0, 1'b0);
    run_frame('{-32768, -1, 0, 0}, 1'b0, 1'b0);

    // Restart mid-frame: the 1000s and the same-cycle 5 are dropped.
    begin_frame();
    send_sample(1000, 1'b0);
    send_sample(1000, 1'b0);
    cyc(1'b1, 1'b1, 5);
    for (int i = 1; i <= 4; i++) send_sample(i, 1'b0);
    finish_frame(10, 1'b0);

    run_frame('{1, 2, 3, 4}, 1'b1, 1'b0);
    run_frame('{-1, -1, -1, 0}, 1'b1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) s[i] = $urandom_range(0, 1) ? 32767 : -32768;
        else begin
          r = 16'($urandom);
          s[i] = r;
        end
      end
      run_frame(s, 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 4; i++) s[i] = $urandom_range(20000, 32767);
      run_frame(s, 1'b0, 1'b0);
    end
    check("cnt_saturated", cnt0, 255);

    run_frame('{32767, 32767, 0, 0}, 1'b0, 1'b1);
    check("cnt_clear_wins", cnt0, 0);
    run_frame('{-32768, -32768, 0, 0}, 1'b0, 1'b0);
    check("cnt_after_clear", cnt0, 1);

    // Asynchronous reset after two accepted samples.
    begin_frame();
    send_sample(500, 1'b0);
    send_sample(600, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out0", out0, 0);
    check("midrst_out2", out2, 0);
    check("midrst_valid0", vld0, 0);
    check("midrst_ready0", rdy0, 0);
    check("midrst_flags0", {cp0, cn0}, 0);
    check("midrst_cnt0", cnt0, 0);
    check("midrst_cnt2", cnt2, 0);
    exp_cnt0 = 0;
    exp_cnt2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1234);
    check("post_rst_no_pulse0", pulses0, frames);
    check("post_rst_out0", out0, 0);
    run_frame('{10, 20, 30, 40}, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
